// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and line levels for the UART transmit path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period tick generator, restarted by clear at each accepted byte
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The last cycle of every bit period is the tick; with one clk per bit every cycle ticks.
    assign bit_tick = (cnt_q == CNT_MAX);

    // Count up, wrap at the end of a bit period, and realign to a fresh period on clear.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART TX engine: start, data LSB-first, optional parity (UART_TX_PARITY_EN), stop
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int UART_BITS_TRANSFERED = 8,
    parameter int CLKS_PER_BIT         = 1,
    parameter int STOP_BITS            = 1,
    parameter int PARITY_ODD           = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [UART_BITS_TRANSFERED-1:0] data_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    output logic                            tx,
    output logic                            busy
);

    localparam int BIT_W = $clog2(UART_BITS_TRANSFERED + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(UART_BITS_TRANSFERED - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_transmitter: CLKS_PER_BIT must be >= 1");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_transmitter: PARITY_ODD must be 0 or 1");
    end

    tx_state_e                       state_q;
    logic [UART_BITS_TRANSFERED-1:0] shift_q;
    logic [BIT_W-1:0]                bit_cnt_q;
    logic                            tx_q;
`ifdef UART_TX_PARITY_EN
    logic                            parity_q;
`endif

    logic handshake;
    logic bit_tick;

    assign handshake  = data_valid && (state_q == IDLE);
    assign data_ready = (state_q == IDLE);
    assign busy       = ~data_ready;
    assign tx         = tx_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (handshake),
        .bit_tick(bit_tick)
    );

    // Frame sequencer; tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= UART_IDLE_LEVEL;
                    if (handshake) begin
                        shift_q   <= data_in;
                        bit_cnt_q <= '0;
                        state_q   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= (^data_in) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: begin
                    tx_q <= UART_START_LEVEL;
                    if (bit_tick) begin
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_q <= parity_q;
                    if (bit_tick) begin
                        bit_cnt_q <= '0;
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    tx_q <= UART_IDLE_LEVEL;
                    if (bit_tick) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    tx_q    <= UART_IDLE_LEVEL;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din1, din4;
    logic       dv1, dv4;
    logic       ready1, tx1, busy1;
    logic       ready4, tx4, busy4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .UART_BITS_TRANSFERED(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut1 (
        .clk(clk), .rst(rst), .data_in(din1), .data_valid(dv1),
        .data_ready(ready1), .tx(tx1), .busy(busy1)
    );

    uart_transmitter #(
        .UART_BITS_TRANSFERED(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut4 (
        .clk(clk), .rst(rst), .data_in(din4), .data_valid(dv4),
        .data_ready(ready4), .tx(tx4), .busy(busy4)
    );

`ifdef UART_TX_PARITY_EN
    logic [7:0] dinp;
    logic       dvp;
    logic       readype, txpe, busype;
    logic       readypo, txpo, busypo;

    uart_transmitter #(
        .UART_BITS_TRANSFERED(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut_pe (
        .clk(clk), .rst(rst), .data_in(dinp), .data_valid(dvp),
        .data_ready(readype), .tx(txpe), .busy(busype)
    );

    uart_transmitter #(
        .UART_BITS_TRANSFERED(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(1)
    ) dut_po (
        .clk(clk), .rst(rst), .data_in(dinp), .data_valid(dvp),
        .data_ready(readypo), .tx(txpo), .busy(busypo)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0]  f;
        logic        txs [0:23];
        logic        rdy [0:23];
        logic [7:0]  rxq [$];
        logic [7:0]  b, b0, b1;
        int          cnt, gap, i;
        logic        stayed_high;

        rst  = 1'b1;
        din1 = 8'h00; dv1 = 1'b0;
        din4 = 8'h00; dv4 = 1'b0;
`ifdef UART_TX_PARITY_EN
        dinp = 8'h00; dvp = 1'b0;
`endif

        // 1. reset held three cycles
        repeat (3) tick();
        chk("rst_tx", tx1, 1'b1);
        chk("rst_ready", ready1, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_tx4", tx4, 1'b1);
        rst = 1'b0;
        tick();
        chk("idle_tx", tx1, 1'b1);
        chk("idle_ready", ready1, 1'b1);

        // 2. single byte 8'hA5 at one clk per bit
        f = {1'b1, 8'hA5, 1'b0};
        din1 = 8'hA5; dv1 = 1'b1;
        tick();
        dv1 = 1'b0;
        din1 = 8'h00;
        chk("a5_hs_tx", tx1, 1'b1);
        chk("a5_hs_ready", ready1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("a5_bit%0d", k), tx1, f[k-1]);
            chk($sformatf("a5_ready%0d", k), ready1, (k == 10));
        end
        tick();
        chk("a5_after_tx", tx1, 1'b1);

        // 3. 8'h3C at four clks per bit
        f = {1'b1, 8'h3C, 1'b0};
        din4 = 8'h3C; dv4 = 1'b1;
        tick();
        dv4 = 1'b0;
        cnt = busy4 ? 1 : 0;
        for (int j = 1; j <= 41; j++) begin
            tick();
            if (busy4) cnt++;
            if (j <= 40) chk($sformatf("3c_tx_c%0d", j), tx4, f[(j-1)/4]);
            if (j == 40) chk("3c_ready_end", ready4, 1'b1);
        end
        chk("3c_tx_idle", tx4, 1'b1);
        chk("3c_busy_cycles", cnt, 40);

        // 4. back-to-back 8'h00 then 8'hFF with data_valid held
        din1 = 8'h00; dv1 = 1'b1;
        tick();
        txs[0] = tx1;
        rdy[0] = ready1;
        din1 = 8'hFF;
        for (int k = 1; k <= 23; k++) begin
            tick();
            txs[k] = tx1;
            rdy[k] = ready1;
            if (k == 11) dv1 = 1'b0;
        end
        cnt = 0;
        for (int k = 1; k <= 11; k++) if (rdy[k]) cnt++;
        chk("b2b_ready_pulses", cnt, 1);
        chk("b2b_ready_at_gap", rdy[10], 1'b1);
        gap = 0;
        for (int k = 10; k <= 23; k++) begin
            if (!txs[k]) break;
            gap++;
        end
        chk("b2b_gap", gap, 2);
        i = 1;
        while (i + 9 <= 23) begin
            if (!txs[i] && txs[i-1]) begin
                for (int n = 0; n < 8; n++) b[n] = txs[i+1+n];
                chk($sformatf("b2b_stop_at%0d", i), txs[i+9], 1'b1);
                rxq.push_back(b);
                i += 10;
            end else begin
                i++;
            end
        end
        b0 = 8'hxx;
        b1 = 8'hxx;
        if (rxq.size() > 0) b0 = rxq[0];
        if (rxq.size() > 1) b1 = rxq[1];
        chk("b2b_frames", rxq.size(), 2);
        chk("b2b_byte0", b0, 8'h00);
        chk("b2b_byte1", b1, 8'hFF);

        // 5. reset during data bit 4 of 8'h81, then a clean 8'h55
        din1 = 8'h81; dv1 = 1'b1;
        tick();
        dv1 = 1'b0;
        repeat (6) tick();
        chk("abort_d4_tx", tx1, 1'b0);
        chk("abort_d4_ready", ready1, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort_tx", tx1, 1'b1);
        chk("abort_ready", ready1, 1'b1);
        chk("abort_busy", busy1, 1'b0);
        rst = 1'b0;
        stayed_high = 1'b1;
        repeat (12) begin
            tick();
            if (tx1 !== 1'b1 || ready1 !== 1'b1) stayed_high = 1'b0;
        end
        chk("abort_stays_idle", stayed_high, 1'b1);
        f = {1'b1, 8'h55, 1'b0};
        din1 = 8'h55; dv1 = 1'b1;
        tick();
        dv1 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("55_bit%0d", k), tx1, f[k-1]);
        end
        chk("55_ready_end", ready1, 1'b1);

`ifdef UART_TX_PARITY_EN
        // 6. parity on 8'h07: even -> 1, odd -> 0
        begin
            logic [10:0] fe, fo;
            fe = {1'b1, 1'b1, 8'h07, 1'b0};
            fo = {1'b1, 1'b0, 8'h07, 1'b0};
            dinp = 8'h07; dvp = 1'b1;
            tick();
            dvp = 1'b0;
            for (int k = 1; k <= 11; k++) begin
                tick();
                chk($sformatf("par_even_bit%0d", k), txpe, fe[k-1]);
                chk($sformatf("par_odd_bit%0d", k), txpo, fo[k-1]);
            end
            chk("par_even_ready", readype, 1'b1);
            chk("par_odd_ready", readypo, 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
